// File: rtl/midi_rx_parser_if.sv
// Bundle of the UART byte feed, Wishbone slave signals and interrupt for midi_rx_parser.
// The master side feeds bytes and issues bus cycles; the slave side is the parser.
interface midi_rx_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] wb_addr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_we_i;
  logic       wb_stb_i;
  logic       wb_ack_o;
  logic       irq_o;

  modport master (
    output rx_data, rx_valid, wb_addr_i, wb_dat_i, wb_we_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, irq_o
  );

  modport slave (
    input  rx_data, rx_valid, wb_addr_i, wb_dat_i, wb_we_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, irq_o
  );
endinterface

// File: rtl/midi_rx_parser.sv
// MIDI byte-stream parser: assembles channel messages into a FIFO read through a Wishbone window.
// Define MIDI_RX_RUNNING_STATUS_EN to let bare data bytes reuse the last channel status.
module midi_rx_parser #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned FIFO_AW   = 3
) (
  input logic             clk,
  input logic             rst,
  midi_rx_parser_if.slave bus
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned MW    = 24;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_D1 = 2'd1;
  localparam logic [1:0] WAIT_D2 = 2'd2;
  localparam logic [1:0] SYSEX   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    d1_q, d1_d;
  logic          push_c;
  logic [MW-1:0] msg_c;

  logic [7:0] rx_b;
  logic       rx_v;
  logic       is_rt_c;
  logic       two_byte_c;
  logic       take_d1_c;

  assign rx_b       = bus.rx_data;
  assign rx_v       = bus.rx_valid;
  assign is_rt_c    = (rx_b[7:3] == 5'b11111);
  assign two_byte_c = (status_q[7:5] == 3'b110);

`ifdef MIDI_RX_RUNNING_STATUS_EN
  logic rs_valid_q, rs_valid_d;
  assign take_d1_c = (state_q == WAIT_D1) || ((state_q == IDLE) && rs_valid_q);
`else
  assign take_d1_c = (state_q == WAIT_D1);
`endif

  // Byte classification and message assembly; realtime bytes never disturb the parse
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
`ifdef MIDI_RX_RUNNING_STATUS_EN
    rs_valid_d = rs_valid_q;
`endif
    push_c = 1'b0;
    msg_c  = '0;
    if (rx_v && !is_rt_c) begin
      if (rx_b[7:4] == 4'hF) begin
        state_d = (rx_b == 8'hF0) ? SYSEX : IDLE;
`ifdef MIDI_RX_RUNNING_STATUS_EN
        rs_valid_d = 1'b0;
`endif
      end else if (rx_b[7]) begin
        status_d = rx_b;
        state_d  = WAIT_D1;
`ifdef MIDI_RX_RUNNING_STATUS_EN
        rs_valid_d = 1'b1;
`endif
      end else if (take_d1_c) begin
        if (two_byte_c) begin
          push_c  = 1'b1;
          msg_c   = {status_q, rx_b, 8'h00};
          state_d = IDLE;
        end else begin
          d1_d    = rx_b;
          state_d = WAIT_D2;
        end
      end else if (state_q == WAIT_D2) begin
        push_c  = 1'b1;
        msg_c   = {status_q, d1_q, rx_b};
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      status_q <= 8'h00;
      d1_q     <= 8'h00;
`ifdef MIDI_RX_RUNNING_STATUS_EN
      rs_valid_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
`ifdef MIDI_RX_RUNNING_STATUS_EN
      rs_valid_q <= rs_valid_d;
`endif
    end
  end

  // Wishbone decode
  logic       ack_q;
  logic [7:0] dat_q;
  logic       irq_q;
  logic       req_c, wr_c, in_win_c;
  logic [8:0] off_full_c;
  logic [3:0] off_c;
  logic [7:0] rd_data_c;

  assign req_c      = bus.wb_stb_i & ~ack_q;
  assign off_full_c = {1'b0, bus.wb_addr_i} - {1'b0, BASE_ADDR};
  assign in_win_c   = ~off_full_c[8] & (off_full_c[7:0] <= 8'd8);
  assign off_c      = off_full_c[3:0];
  assign wr_c       = req_c & bus.wb_we_i & in_win_c;

  // Message FIFO
  logic [MW-1:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               full_c, nempty_c, pop_c, keep_c, push_ok_c, ovf_set_c;
  logic [MW-1:0]      head_c;
  logic [15:0]        chan_mask_q;
  logic               rt_q, ovf_q;
  logic [7:0]         realtime_q;

  assign full_c    = (count_q == CW'(DEPTH));
  assign nempty_c  = (count_q != '0);
  assign pop_c     = wr_c & (off_c == 4'd5) & nempty_c;
  assign keep_c    = chan_mask_q[msg_c[19:16]];
  // A same-cycle pop frees the slot the push needs
  assign push_ok_c = push_c & keep_c & (~full_c | pop_c);
  assign ovf_set_c = push_c & keep_c & full_c & ~pop_c;
  assign head_c    = nempty_c ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= msg_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q <= count_q + CW'(push_ok_c) - CW'(pop_c);
    end
  end

  // Sticky flags: a set in the same cycle outranks a write-one-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      rt_q        <= 1'b0;
      ovf_q       <= 1'b0;
      realtime_q  <= 8'h00;
      chan_mask_q <= 16'hFFFF;
    end else begin
      if (rx_v && is_rt_c) begin
        rt_q       <= 1'b1;
        realtime_q <= rx_b;
      end else if (wr_c && off_c == 4'd0 && bus.wb_dat_i[3]) begin
        rt_q <= 1'b0;
      end
      if (ovf_set_c) ovf_q <= 1'b1;
      else if (wr_c && off_c == 4'd0 && bus.wb_dat_i[2]) ovf_q <= 1'b0;
      if (wr_c && off_c == 4'd7) chan_mask_q[7:0]  <= bus.wb_dat_i;
      if (wr_c && off_c == 4'd8) chan_mask_q[15:8] <= bus.wb_dat_i;
    end
  end

  always_comb begin
    rd_data_c = 8'h00;
    if (in_win_c) begin
      case (off_c)
        4'd0:    rd_data_c = {4'b0000, rt_q, ovf_q, full_c, nempty_c};
        4'd1:    rd_data_c = realtime_q;
        4'd2:    rd_data_c = head_c[23:16];
        4'd3:    rd_data_c = head_c[15:8];
        4'd4:    rd_data_c = head_c[7:0];
        4'd6:    rd_data_c = 8'(count_q);
        4'd7:    rd_data_c = chan_mask_q[7:0];
        4'd8:    rd_data_c = chan_mask_q[15:8];
        default: rd_data_c = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      dat_q <= 8'h00;
      irq_q <= 1'b0;
    end else begin
      ack_q <= req_c;
      dat_q <= req_c ? rd_data_c : 8'h00;
      irq_q <= nempty_c | rt_q;
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.irq_o    = irq_q;
endmodule

// File: tb/tb_midi_rx_parser.sv
// Randomized and directed bench for midi_rx_parser against a queue-based MIDI message model.
module tb_midi_rx_parser;
  localparam int unsigned AW    = 3;
  localparam int          DEPTH = 8;
  localparam logic [7:0]  BASE  = 8'h00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  midi_rx_parser_if bus ();
  midi_rx_parser #(.BASE_ADDR(BASE), .FIFO_AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: completed messages, the bytes of the message being gathered, flags and registers
  bit [23:0] mq[$];
  bit [7:0]  pend[$];
  bit        m_ovf, m_rt, m_ack;
  bit [7:0]  m_rtb;
  bit [15:0] m_mask;
`ifdef MIDI_RX_RUNNING_STATUS_EN
  bit [7:0]  m_rs;
  bit        m_rs_v;
`endif
  bit        exp_ack = 1'b0;
  bit        exp_irq = 1'b0;
  bit [7:0]  exp_dat = 8'h00;
  bit        chk_en  = 1'b1;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int msg_len(input bit [7:0] s);
    return (s >= 8'hC0 && s <= 8'hDF) ? 2 : 3;
  endfunction

  function automatic bit [7:0] m_read(input bit [7:0] a);
    int off;
    off = int'(a) - int'(BASE);
    if (off < 0 || off > 8) return 8'h00;
    case (off)
      0: return {4'b0000, m_rt, m_ovf, mq.size() == DEPTH, mq.size() != 0};
      1: return m_rtb;
      2: return (mq.size() > 0) ? mq[0][23:16] : 8'h00;
      3: return (mq.size() > 0) ? mq[0][15:8] : 8'h00;
      4: return (mq.size() > 0) ? mq[0][7:0] : 8'h00;
      6: return 8'(mq.size());
      7: return m_mask[7:0];
      8: return m_mask[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    pend.delete();
    m_ovf = 0; m_rt = 0; m_ack = 0; m_rtb = 8'h00; m_mask = 16'hFFFF;
`ifdef MIDI_RX_RUNNING_STATUS_EN
    m_rs = 8'h00; m_rs_v = 0;
`endif
  endtask

  // Advance the model by one clock; expectations describe the outputs after that edge
  task automatic model_step(input bit rv, input bit [7:0] rb, input bit stb, input bit we,
                            input bit [7:0] a, input bit [7:0] wd);
    bit req, wr, have, rts, ovf_set;
    bit [23:0] msg;
    bit [7:0] d2;
    int off;
    exp_irq = (mq.size() != 0) || m_rt;
    req = stb && !m_ack;
    exp_dat = req ? m_read(a) : 8'h00;
    exp_ack = req;
    m_ack = req;
    off = int'(a) - int'(BASE);
    wr = req && we && off >= 0 && off <= 8;
    have = 0; rts = 0; ovf_set = 0; msg = '0;
    if (rv) begin
      if (rb >= 8'hF8) begin
        rts = 1; m_rtb = rb;
      end else if (rb >= 8'hF0) begin
        pend.delete();
`ifdef MIDI_RX_RUNNING_STATUS_EN
        m_rs_v = 0;
`endif
      end else if (rb >= 8'h80) begin
        pend.delete();
        pend.push_back(rb);
`ifdef MIDI_RX_RUNNING_STATUS_EN
        m_rs = rb; m_rs_v = 1;
`endif
      end else begin
        if (pend.size() > 0) pend.push_back(rb);
`ifdef MIDI_RX_RUNNING_STATUS_EN
        else if (m_rs_v) begin pend.push_back(m_rs); pend.push_back(rb); end
`endif
        if (pend.size() > 0 && pend.size() == msg_len(pend[0])) begin
          d2 = 8'h00;
          if (pend.size() == 3) d2 = pend[2];
          msg = {pend[0], pend[1], d2};
          pend.delete();
          have = m_mask[msg[19:16]];
        end
      end
    end
    if (wr && off == 5 && mq.size() > 0) void'(mq.pop_front());
    if (have) begin
      if (mq.size() < DEPTH) mq.push_back(msg);
      else ovf_set = 1;
    end
    if (wr && off == 0) begin
      if (wd[3]) m_rt = 0;
      if (wd[2]) m_ovf = 0;
    end
    if (rts) m_rt = 1;
    if (ovf_set) m_ovf = 1;
    if (wr && off == 7) m_mask[7:0] = wd;
    if (wr && off == 8) m_mask[15:8] = wd;
  endtask

  task automatic cyc(input bit rv, input bit [7:0] rb, input bit stb, input bit we,
                     input bit [7:0] a, input bit [7:0] wd);
    @(negedge clk);
    bus.rx_valid = rv; bus.rx_data = rb;
    bus.wb_stb_i = stb; bus.wb_we_i = we; bus.wb_addr_i = a; bus.wb_dat_i = wd;
    model_step(rv, rb, stb, we, a, wd);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic send(input bit [7:0] b);
    cyc(1, b, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic wb_write(input bit [7:0] a, input bit [7:0] d);
    cyc(0, 8'h00, 1, 1, a, d);
    idle(1);
  endtask

  task automatic rd_chk(input string nm, input bit [7:0] a, input bit [7:0] exp);
    logic [7:0] d;
    cyc(0, 8'h00, 1, 0, a, 8'h00);
    #1;
    d = bus.wb_dat_o;
    chk(nm, d, exp);
    idle(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    bus.rx_valid = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
    model_reset();
    exp_ack = 0; exp_irq = 0; exp_dat = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_dat", bus.wb_dat_o, 8'h00);
    @(negedge clk);
    rst = 0;
    model_step(0, 8'h00, 0, 0, 8'h00, 8'h00);
    @(posedge clk);
  endtask

  // Every cycle: DUT outputs against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("ack", 8'(bus.wb_ack_o), 8'(exp_ack));
      if (exp_ack) chk("rdata", bus.wb_dat_o, exp_dat);
      chk("irq", 8'(bus.irq_o), 8'(exp_irq));
    end
  end

  initial begin
    rst = 1;
    bus.rx_valid = 0; bus.rx_data = 8'h00;
    bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_addr_i = 8'h00; bus.wb_dat_i = 8'h00;
    model_reset();
    do_reset();

    rd_chk("rst_stat", 8'd0, 8'h00);
    rd_chk("rst_count", 8'd6, 8'h00);
    rd_chk("rst_rt", 8'd1, 8'h00);
    rd_chk("rst_mlo", 8'd7, 8'hFF);
    rd_chk("rst_mhi", 8'd8, 8'hFF);

    send(8'h90); send(8'h3C); send(8'h64); idle(2);
    rd_chk("n1_count", 8'd6, 8'h01);
    rd_chk("n1_st", 8'd2, 8'h90);
    rd_chk("n1_d1", 8'd3, 8'h3C);
    rd_chk("n1_d2", 8'd4, 8'h64);
    chk("n1_irq", 8'(bus.irq_o), 8'h01);

    do_reset();
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64); idle(1);
    rd_chk("rt_count", 8'd6, 8'h01);
    rd_chk("rt_st", 8'd2, 8'h90);
    rd_chk("rt_d1", 8'd3, 8'h3C);
    rd_chk("rt_d2", 8'd4, 8'h64);
    rd_chk("rt_val", 8'd1, 8'hF8);
    rd_chk("rt_stat", 8'd0, 8'h09);

    do_reset();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h00); idle(1);
`ifdef MIDI_RX_RUNNING_STATUS_EN
    rd_chk("rs_count", 8'd6, 8'h02);
    wb_write(8'd5, 8'h00);
    rd_chk("rs_st", 8'd2, 8'h90);
    rd_chk("rs_d1", 8'd3, 8'h40);
    rd_chk("rs_d2", 8'd4, 8'h00);
`else
    rd_chk("nors_count", 8'd6, 8'h01);
`endif

    do_reset();
    send(8'h90); send(8'h3C); send(8'hB0); send(8'h07); send(8'h7F); idle(1);
    rd_chk("ab_count", 8'd6, 8'h01);
    rd_chk("ab_st", 8'd2, 8'hB0);
    rd_chk("ab_d1", 8'd3, 8'h07);
    rd_chk("ab_d2", 8'd4, 8'h7F);

    do_reset();
    send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'hC5); send(8'h10); idle(1);
    rd_chk("sx_count", 8'd6, 8'h01);
    rd_chk("sx_st", 8'd2, 8'hC5);
    rd_chk("sx_d1", 8'd3, 8'h10);
    rd_chk("sx_d2", 8'd4, 8'h00);

    do_reset();
    for (int i = 0; i < 9; i++) begin send(8'hC5); send(8'(i)); end
    idle(1);
    rd_chk("of_count", 8'd6, 8'h08);
    rd_chk("of_stat", 8'd0, 8'h07);
    wb_write(8'd0, 8'h04);
    rd_chk("of_clr", 8'd0, 8'h03);
    send(8'hC5);
    cyc(1, 8'h11, 1, 1, 8'd5, 8'h00);
    idle(1);
    rd_chk("pp_count", 8'd6, 8'h08);
    rd_chk("pp_stat", 8'd0, 8'h03);

    do_reset();
    wb_write(8'd7, 8'hFE);
    send(8'h90); send(8'h3C); send(8'h64); idle(1);
    rd_chk("mk_count0", 8'd6, 8'h00);
    rd_chk("mk_stat", 8'd0, 8'h00);
    send(8'h91); send(8'h3C); send(8'h64); idle(1);
    rd_chk("mk_count1", 8'd6, 8'h01);

    do_reset();
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64); idle(1);
    rd_chk("mid_rst", 8'd6, 8'h00);
    wb_write(8'h20, 8'h00);
    rd_chk("oow_rd", 8'h20, 8'h00);
    rd_chk("oow_mlo", 8'd7, 8'hFF);

    for (int i = 0; i < 4000; i++) begin
      bit rv, stb, we;
      bit [7:0] rb, a, wd;
      int r, ra;
      rv = ($urandom_range(0, 2) == 0);
      r = int'($urandom_range(0, 15));
      if (r <= 6 || r == 15) rb = 8'($urandom_range(0, 127));
      else if (r <= 10) rb = 8'($urandom_range(128, 239));
      else if (r == 11) rb = 8'($urandom_range(248, 255));
      else if (r == 12) rb = 8'hF0;
      else if (r == 13) rb = 8'hF7;
      else rb = 8'($urandom_range(241, 246));
      stb = ($urandom_range(0, 3) == 0);
      we = 1'($urandom_range(0, 1));
      ra = int'($urandom_range(0, 11));
      if (ra <= 8) a = 8'(ra);
      else if (ra <= 10) a = 8'd5;
      else a = 8'($urandom);
      wd = 8'($urandom);
      if ((a == 8'd7 || a == 8'd8) && $urandom_range(0, 3) != 0) wd = 8'hFF;
      if (i == 2000) do_reset();
      else cyc(rv, rb, stb, we, a, wd);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
